axis_pattern_sink: RTL and testbench
====================================

AXIS_PATTERN_SINK -- requirements
Module: axis_pattern_sink

Interface
REQ-001 SHALL have parameter DSIZE, default 16, meaning data width of sink_inf.axis_tdata.
REQ-002 SHALL have parameter MAX_LEN, default 1024, meaning largest supported frame length in beats.
REQ-003 SHALL have port clock, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port sink_inf, axi_stream_inf.slave, DSIZE, the stream input; the block drives axis_tready and samples axis_tvalid, axis_tdata and axis_tlast.
REQ-006 SHALL have port cfg_len, input, $clog2(MAX_LEN+1), the expected beats per frame; 0 disables the length check.
REQ-007 SHALL have port frame_done, output, 1, a one-cycle pulse on acceptance of a tlast beat.
REQ-008 SHALL have port frame_cnt, output, 32, the number of completed frames.
REQ-009 SHALL have port err_cnt, output, 16, the number of frames that contained at least one error.
REQ-010 SHALL have port last_len, output, $clog2(MAX_LEN+1), the beat count of the most recently completed frame.
REQ-011 SHALL have port err_flag, output, 1, sticky error indication, set on any error.

Function
REQ-012 SHALL accept a beat only when axis_tvalid and axis_tready are both 1 in the same cycle; no other cycle counts.
REQ-013 SHALL implement a state machine with three states: IDLE, BODY and OVERRUN.
- IDLE: an accepted beat with tlast=0 moves to BODY; an accepted beat with tlast=1 completes a one-beat frame and stays in IDLE.
- BODY: an accepted beat with tlast=1 returns to IDLE.
- BODY: if the beat count reaches MAX_LEN without tlast, move to OVERRUN.
- OVERRUN: discard beats (tready held 1), take no data checks, and return to IDLE on the accepted tlast.
REQ-014 SHALL capture the first beat of each frame as the seed; each later beat SHALL equal previous data+1 modulo 2^DSIZE, so 16'hFFFF followed by 16'h0000 is valid.
REQ-015 SHALL flag a length error when cfg_len≠0 and either tlast arrives on a beat other than beat number cfg_len, or beat number cfg_len arrives without tlast.
- After a missing tlast, further beats are not checked for length until tlast.
REQ-016 SHALL flag a frame as errored on any data mismatch, any length error, or entry to OVERRUN.
- err_cnt increments at most once per frame, in the frame_done cycle, and saturates at 16'hFFFF.
REQ-017 SHALL update frame_cnt (wrapping), err_cnt and last_len, and pulse frame_done, one cycle after the tlast beat is accepted.
- Latency from tlast acceptance to frame_done high is exactly 1 cycle.
REQ-018 SHALL set err_flag in the same cycle as frame_done of the errored frame; err_flag clears only on rst.
REQ-019 SHALL sample cfg_len on the first beat of each frame and hold it for the whole frame; changes mid-frame SHALL NOT affect that frame.
REQ-020 SHALL never combinationally depend axis_tready on axis_tvalid.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, force: state IDLE, axis_tready 0, frame_done 0, frame_cnt 0, err_cnt 0, last_len 0, err_flag 0, LFSR to 16'hACE1.
REQ-022 SHALL drive axis_tready from the first cycle after rst deasserts, per the Configuration section.
REQ-023 SHALL abandon a partial frame when rst is asserted mid-frame, without counting it and without a frame_done pulse.

Configuration
REQ-024 SHALL use macro AXIS_PATTERN_SINK_BACKPRESSURE_EN, which selects how axis_tready is driven outside reset.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle, and axis_tready is registered from LFSR bit 0, giving pseudo-random throttling.
- Not defined: axis_tready is constant 1 outside reset, and no LFSR is built.

Structure
REQ-025 SHALL place the state enum (IDLE, BODY, OVERRUN), the LFSR seed constant and the tap mask in package axis_pattern_sink_pkg.
REQ-026 SHALL implement the LFSR as sub-module axis_bp_lfsr (ports clock, rst, ready_out), instantiated only when the macro is defined.

Verification
REQ-027 SHALL verify the basic frame: cfg_len=4, beats 16'h0010, 0011, 0012, 0013 with tlast on the fourth.
- Required: frame_done pulse, frame_cnt=1, last_len=4, err_cnt=0.
REQ-028 SHALL verify data wrap: cfg_len=3, beats 16'hFFFE, FFFF, 0000 with tlast on the third.
- Required: no error, err_flag=0.
REQ-029 SHALL verify a data mismatch: cfg_len=0, beats 5, 6, 8 with tlast on the third.
- Required: err_cnt=1, err_flag=1, last_len=3.
REQ-030 SHALL verify early tlast: cfg_len=8, tlast on beat 5.
- Required: err_cnt=1, last_len=5.
- The following correct 8-beat frame leaves err_cnt at 1.
REQ-031 SHALL verify overrun: MAX_LEN=16, a 20-beat frame.
- Required: OVERRUN entered at beat 16, frame_done one cycle after beat 20, err_cnt=1.
REQ-032 SHALL verify reset mid-frame with AXIS_PATTERN_SINK_BACKPRESSURE_EN defined: rst asserted after beat 2 of a 6-beat frame.
- Required: all counters 0, no frame_done.
- A subsequent clean frame counts as frame_cnt=1.
- tready toggles across the run, and no beat is lost.

Source files
------------

// File: rtl/axis_pattern_sink_pkg.sv
// Shared types and constants for the AXI-Stream pattern sink.
// The LFSR constants are only consumed when AXIS_PATTERN_SINK_BACKPRESSURE_EN is defined.
package axis_pattern_sink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BODY    = 2'd1,
    OVERRUN = 2'd2
  } sink_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsrFeedback(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// Minimal AXI-Stream bundle: the source drives valid/data/last, the sink drives ready.
interface axi_stream_inf #(
  parameter int DSIZE = 16
) ();

  logic             axis_tvalid;
  logic             axis_tready;
  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tlast;

  modport master (
    output axis_tvalid,
    output axis_tdata,
    output axis_tlast,
    input  axis_tready
  );

  modport slave (
    input  axis_tvalid,
    input  axis_tdata,
    input  axis_tlast,
    output axis_tready
  );

endinterface

// File: rtl/axis_pattern_sink_lfsr.sv
// 16-bit Fibonacci LFSR that throttles the sink's tready pseudo-randomly.
// Only instantiated when AXIS_PATTERN_SINK_BACKPRESSURE_EN is defined.
module axis_bp_lfsr
  import axis_pattern_sink_pkg::*;
(
  input  logic clock,
  input  logic rst,
  output logic ready_out
);

  logic [15:0] r_lfsr;
  logic        r_ready;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_lfsr  <= LFSR_SEED;
      r_ready <= 1'b0;
    end else begin
      r_lfsr  <= {r_lfsr[14:0], lfsrFeedback(r_lfsr)};
      r_ready <= r_lfsr[0];
    end
  end

  assign ready_out = r_ready;

endmodule

// File: rtl/axis_pattern_sink.sv
// AXI-Stream sink that checks incrementing-data frames, optional expected length and overruns.
// Define AXIS_PATTERN_SINK_BACKPRESSURE_EN to throttle tready from an LFSR instead of holding it high.
module axis_pattern_sink
  import axis_pattern_sink_pkg::*;
#(
  parameter int DSIZE   = 16,
  parameter int MAX_LEN = 1024
) (
  input  logic                         clock,
  input  logic                         rst,
  axi_stream_inf.slave                 sink_inf,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  output logic                         frame_done,
  output logic [31:0]                  frame_cnt,
  output logic [15:0]                  err_cnt,
  output logic [$clog2(MAX_LEN+1)-1:0] last_len,
  output logic                         err_flag
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] MAX_BEATS = LW'(MAX_LEN);

  sink_state_e      r_state;
  logic [DSIZE-1:0] r_prevData;
  logic [LW-1:0]    r_beatCnt;
  logic [LW-1:0]    r_lenCfg;
  logic             r_lenDead;
  logic             r_frameErr;
  logic             r_frameDone;
  logic [31:0]      r_frameCnt;
  logic [15:0]      r_errCnt;
  logic [LW-1:0]    r_lastLen;
  logic             r_errFlag;

  logic             w_tready;
  logic             w_accept;
  logic             w_tlast;
  logic [DSIZE-1:0] w_data;
  logic [LW-1:0]    w_cnt;
  logic [LW-1:0]    w_len;
  logic             w_lenDead;
  logic             w_prevErr;
  logic             w_checking;
  logic             w_dataErr;
  logic             w_lenErr;
  logic             w_lenMiss;
  logic             w_enterOverrun;
  logic             w_beatErr;
  logic             w_frameErrNext;

`ifdef AXIS_PATTERN_SINK_BACKPRESSURE_EN
  logic w_lfsrReady;

  axis_bp_lfsr u_bpLfsr (
    .clock     (clock),
    .rst       (rst),
    .ready_out (w_lfsrReady)
  );

  assign w_tready = w_lfsrReady;
`else
  logic r_tready;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= 1'b1;
    end
  end

  assign w_tready = r_tready;
`endif

  assign sink_inf.axis_tready = w_tready;
  assign w_accept = sink_inf.axis_tvalid & w_tready;
  assign w_tlast  = sink_inf.axis_tlast;
  assign w_data   = sink_inf.axis_tdata;

  // Per-beat view of the frame: a beat seen in IDLE starts a fresh frame context
  always_comb begin
    w_cnt          = '0;
    w_len          = '0;
    w_lenDead      = 1'b0;
    w_prevErr      = 1'b0;
    w_checking     = 1'b0;
    w_dataErr      = 1'b0;
    w_lenErr       = 1'b0;
    w_lenMiss      = 1'b0;
    w_enterOverrun = 1'b0;
    if (r_state == IDLE) begin
      w_cnt     = LW'(1);
      w_len     = cfg_len;
      w_lenDead = 1'b0;
      w_prevErr = 1'b0;
    end else begin
      w_cnt     = (r_beatCnt == '1) ? r_beatCnt : r_beatCnt + LW'(1);
      w_len     = r_lenCfg;
      w_lenDead = r_lenDead;
      w_prevErr = r_frameErr;
    end
    w_checking = (r_state != OVERRUN);
    if (w_checking && r_state == BODY) begin
      w_dataErr = (w_data != r_prevData + DSIZE'(1));
    end
    if (w_checking && w_len != '0 && !w_lenDead) begin
      w_lenErr  = w_tlast ? (w_cnt != w_len) : (w_cnt == w_len);
      w_lenMiss = !w_tlast && (w_cnt == w_len);
    end
    w_enterOverrun = w_checking && !w_tlast && (w_cnt == MAX_BEATS);
  end

  assign w_beatErr      = w_dataErr | w_lenErr | w_enterOverrun;
  assign w_frameErrNext = w_prevErr | w_beatErr;

  // Frame FSM plus the registered status outputs, which publish one cycle after tlast
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prevData  <= '0;
      r_beatCnt   <= '0;
      r_lenCfg    <= '0;
      r_lenDead   <= 1'b0;
      r_frameErr  <= 1'b0;
      r_frameDone <= 1'b0;
      r_frameCnt  <= '0;
      r_errCnt    <= '0;
      r_lastLen   <= '0;
      r_errFlag   <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_accept) begin
        r_prevData <= w_data;
        r_beatCnt  <= w_cnt;
        r_lenCfg   <= w_len;
        r_lenDead  <= w_lenDead | w_lenMiss;
        r_frameErr <= w_frameErrNext;
        if (w_tlast) begin
          r_state     <= IDLE;
          r_frameDone <= 1'b1;
          r_frameCnt  <= r_frameCnt + 32'd1;
          r_lastLen   <= w_cnt;
          if (w_frameErrNext) begin
            r_errFlag <= 1'b1;
            if (r_errCnt != 16'hFFFF) begin
              r_errCnt <= r_errCnt + 16'd1;
            end
          end
        end else if (w_enterOverrun) begin
          r_state <= OVERRUN;
        end else if (r_state == IDLE) begin
          r_state <= BODY;
        end
      end
    end
  end

  assign frame_done = r_frameDone;
  assign frame_cnt  = r_frameCnt;
  assign err_cnt    = r_errCnt;
  assign last_len   = r_lastLen;
  assign err_flag   = r_errFlag;

endmodule

// File: tb/tb_axis_pattern_sink.sv
// Directed bench for axis_pattern_sink (MAX_LEN=16); works with or without
// AXIS_PATTERN_SINK_BACKPRESSURE_EN since every beat waits for the handshake.
module tb_axis_pattern_sink;

  logic        clock;
  logic        rst;
  logic [4:0]  cfg_len;
  logic        frame_done;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [4:0]  last_len;
  logic        err_flag;

  int total = 0;
  int bad = 0;
  int donePulses = 0;
  int expPulses = 0;
  int readyToggles = 0;
  logic prevReady = 1'b0;

  axi_stream_inf #(.DSIZE(16)) sinkBus ();

  axis_pattern_sink #(.DSIZE(16), .MAX_LEN(16)) dut (
    .clock      (clock),
    .rst        (rst),
    .sink_inf   (sinkBus),
    .cfg_len    (cfg_len),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .last_len   (last_len),
    .err_flag   (err_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse and tready activity monitor, sampled before the edge's updates land
  always @(posedge clock) begin
    if (frame_done) donePulses++;
    if (!rst && sinkBus.axis_tready != prevReady) readyToggles++;
    prevReady = sinkBus.axis_tready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sends nBeats of seed+i; beats from badBeat on are shifted by one so only that beat breaks the sequence
  task automatic applyStimulus(input logic [4:0] len, input logic [4:0] lenAfter,
                               input logic [15:0] seed, input int nBeats,
                               input int badBeat, input bit withLast);
    cfg_len = len;
    for (int i = 0; i < nBeats; i++) begin
      sinkBus.axis_tdata  = seed + 16'(i) + ((badBeat >= 0 && i >= badBeat) ? 16'd1 : 16'd0);
      sinkBus.axis_tlast  = withLast && (i == nBeats - 1);
      sinkBus.axis_tvalid = 1'b1;
      for (int c = 0; c < 200; c++) begin
        if (sinkBus.axis_tready) break;
        @(negedge clock);
      end
      checkOutput("readyWait", 32'(sinkBus.axis_tready), 32'd1);
      @(negedge clock);
      if (i == 0) cfg_len = lenAfter;
    end
    sinkBus.axis_tvalid = 1'b0;
    sinkBus.axis_tlast  = 1'b0;
  endtask

  task automatic checkFrame(input int expCnt, input int expErr, input int expLen, input int expFlag);
    checkOutput("frameDone", 32'(frame_done), 32'd1);
    checkOutput("frameCnt", frame_cnt, 32'(expCnt));
    checkOutput("errCnt", 32'(err_cnt), 32'(expErr));
    checkOutput("lastLen", 32'(last_len), 32'(expLen));
    checkOutput("errFlag", 32'(err_flag), 32'(expFlag));
    @(negedge clock);
    checkOutput("doneWidth", 32'(frame_done), 32'd0);
    expPulses++;
    checkOutput("donePulses", 32'(donePulses), 32'(expPulses));
  endtask

  initial begin
    rst = 1'b1;
    cfg_len = '0;
    sinkBus.axis_tvalid = 1'b0;
    sinkBus.axis_tdata  = '0;
    sinkBus.axis_tlast  = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rstReady", 32'(sinkBus.axis_tready), 32'd0);
    checkOutput("rstDone", 32'(frame_done), 32'd0);
    checkOutput("rstFrameCnt", frame_cnt, 32'd0);
    checkOutput("rstErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("rstLastLen", 32'(last_len), 32'd0);
    checkOutput("rstErrFlag", 32'(err_flag), 32'd0);
    rst = 1'b0;
    @(negedge clock);
`ifndef AXIS_PATTERN_SINK_BACKPRESSURE_EN
    checkOutput("readyHigh", 32'(sinkBus.axis_tready), 32'd1);
`endif

    applyStimulus(5'd4, 5'd4, 16'h0010, 4, -1, 1'b1);
    checkFrame(1, 0, 4, 0);
    applyStimulus(5'd3, 5'd3, 16'hFFFE, 3, -1, 1'b1);
    checkFrame(2, 0, 3, 0);
    applyStimulus(5'd0, 5'd0, 16'h0005, 3, 2, 1'b1);
    checkFrame(3, 1, 3, 1);
    applyStimulus(5'd8, 5'd8, 16'h0100, 5, -1, 1'b1);
    checkFrame(4, 2, 5, 1);
    applyStimulus(5'd8, 5'd8, 16'h0200, 8, -1, 1'b1);
    checkFrame(5, 2, 8, 1);
    applyStimulus(5'd2, 5'd2, 16'h0001, 3, 1, 1'b1);
    checkFrame(6, 3, 3, 1);
    applyStimulus(5'd3, 5'd5, 16'h0300, 3, -1, 1'b1);
    checkFrame(7, 3, 3, 1);
    applyStimulus(5'd16, 5'd16, 16'h0400, 16, -1, 1'b1);
    checkFrame(8, 3, 16, 1);
    applyStimulus(5'd0, 5'd0, 16'h0000, 20, -1, 1'b1);
    checkFrame(9, 4, 20, 1);
    applyStimulus(5'd1, 5'd1, 16'h0077, 1, -1, 1'b1);
    checkFrame(10, 4, 1, 1);
    applyStimulus(5'd2, 5'd2, 16'h0088, 1, -1, 1'b1);
    checkFrame(11, 5, 1, 1);

    applyStimulus(5'd6, 5'd6, 16'h0040, 2, -1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checkOutput("midRstFrameCnt", frame_cnt, 32'd0);
    checkOutput("midRstErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("midRstLastLen", 32'(last_len), 32'd0);
    checkOutput("midRstErrFlag", 32'(err_flag), 32'd0);
    checkOutput("midRstPulses", 32'(donePulses), 32'(expPulses));
    applyStimulus(5'd6, 5'd6, 16'h0050, 6, -1, 1'b1);
    checkFrame(1, 0, 6, 0);
`ifdef AXIS_PATTERN_SINK_BACKPRESSURE_EN
    checkOutput("readyToggles", 32'(readyToggles >= 4), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
